// File: rtl/alm_soa_pipe_if.sv
// Stream interface for the approximate log multiplier: operand pair in,
// signed product out, plus a busy indication.
interface alm_soa_pipe_if #(
    parameter int N     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [N:0]       x_i;
    logic [N:0]       y_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [2*N:0]     p_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    // Multiplier side
    modport slave (
        input  in_valid_i, x_i, y_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, p_o, tag_o, busy_o
    );

    // Producer/consumer side
    modport master (
        output in_valid_i, x_i, y_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, p_o, tag_o, busy_o
    );
endinterface

// File: rtl/alm_soa_pipe.sv
// Three-stage approximate logarithmic multiplier with set-one-adder
// truncation. Stage 1 encodes both magnitudes into the log domain, stage 2
// adds them, stage 3 converts back and applies sign/zero. A single global
// enable stalls every stage together when the output is blocked.
module alm_soa_pipe #(
    parameter int N     = 8,
    parameter int T     = 3,
    parameter int TAG_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alm_soa_pipe_if.slave   bus
);
    localparam int K  = $clog2(N);
    localparam int F  = N - 1 - T;
    localparam int W  = K + F;
    localparam int GI = (T > 0) ? T - 1 : 0;
    localparam logic [N-2:0] LOW_ONES = (N-1)'((64'd1 << T) - 64'd1);

    // Returns {k, frac[N-2:T], frac[T-1]}; the last bit is the soa guard
    // (forced 0 when nothing is truncated).
    function automatic logic [W:0] encode(input logic [N-1:0] m);
        logic [K-1:0] k;
        logic [N-1:0] sh;
        logic         g;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) k = K'(i);
        end
        sh = m << (K'(N - 1) - k);
        g  = (T > 0) ? sh[GI] : 1'b0;
        return {k, sh[N-2:T], g};
    endfunction

    logic             en;
    logic             in_ready;
    logic [W:0]       enc_x;
    logic [W:0]       enc_y;

    logic             s1_valid;
    logic [W-1:0]     s1_op_x;
    logic [W-1:0]     s1_op_y;
    logic             s1_c;
    logic             s1_sign;
    logic             s1_zero;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [W:0]       s2_l;
    logic             s2_sign;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    logic             s3_valid;
    logic [2*N:0]     s3_p;
    logic [TAG_W-1:0] s3_tag;

    logic [W:0]       sum;
    logic [K:0]       e;
    logic [N-2:0]     g_frac;
    logic [2*N-1:0]   wide;
    logic [2*N-1:0]   mag;
    logic [2*N:0]     p_next;

    assign en       = bus.out_ready_i | ~s3_valid;
    assign in_ready = en & ~rst_i;
    assign enc_x    = encode(bus.x_i[N-1:0]);
    assign enc_y    = encode(bus.y_i[N-1:0]);

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s3_valid;
    assign bus.p_o         = s3_p;
    assign bus.tag_o       = s3_tag;
    assign bus.busy_o      = s1_valid | s2_valid | s3_valid;

    // Log-domain addition and antilog shift feeding stage 3.
    always_comb begin
        sum    = {1'b0, s1_op_x} + {1'b0, s1_op_y} + {{W{1'b0}}, s1_c};
        e      = s2_l[W:F];
        g_frac = ((N-1)'(s2_l[F-1:0]) << T) | LOW_ONES;
        wide   = {{N{1'b0}}, 1'b1, g_frac};
        if (e >= (K+1)'(N - 1)) begin
            mag = wide << (e - (K+1)'(N - 1));
        end else begin
            mag = wide >> ((K+1)'(N - 1) - e);
        end
        p_next = s2_zero ? '0 : {s2_sign, mag};
    end

    // Pipeline registers: all stages advance together on en, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_op_x  <= '0;
            s1_op_y  <= '0;
            s1_c     <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_l     <= '0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
            s3_valid <= 1'b0;
            s3_p     <= '0;
            s3_tag   <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid_i & in_ready;
            s1_op_x  <= enc_x[W:1];
            s1_op_y  <= enc_y[W:1];
            s1_c     <= enc_x[0] & enc_y[0];
            s1_sign  <= bus.x_i[N] ^ bus.y_i[N];
            s1_zero  <= (bus.x_i[N-1:0] == '0) | (bus.y_i[N-1:0] == '0);
            s1_tag   <= bus.tag_i;
            s2_valid <= s1_valid;
            s2_l     <= sum;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_tag   <= s1_tag;
            s3_valid <= s2_valid;
            s3_p     <= p_next;
            s3_tag   <= s2_tag;
        end
    end
endmodule

// File: tb/tb_alm_soa_pipe.sv
// Bench for alm_soa_pipe: directed vectors, backpressure, mid-stream reset
// and random streams on three parameter sets against an arithmetic model.
module tb_alm_soa_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alm_soa_pipe_if #(.N(8),  .TAG_W(4)) bus8();
    alm_soa_pipe_if #(.N(16), .TAG_W(4)) bus16();
    alm_soa_pipe_if #(.N(8),  .TAG_W(4)) bus0();

    alm_soa_pipe #(.N(8),  .T(3), .TAG_W(4)) dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
    alm_soa_pipe #(.N(16), .T(5), .TAG_W(4)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));
    alm_soa_pipe #(.N(8),  .T(0), .TAG_W(4)) dut_t0(.clk_i(clk), .rst_i(rst), .bus(bus0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned lead(longint unsigned m);
        longint unsigned k = 0;
        while ((m >> (k + 1)) != 0) k++;
        return k;
    endfunction

    function automatic longint unsigned frac_of(int n, longint unsigned m);
        return (m << (n - 1 - lead(m))) & ((64'd1 << (n - 1)) - 1);
    endfunction

    // Bit-accurate reference: log encode, soa add, antilog, sign/zero.
    function automatic longint unsigned model(int n, int t, longint unsigned x, longint unsigned y);
        longint unsigned mx, my, sgn, f, opx, opy, c, l, e, g, mm, mag;
        mx  = x & ((64'd1 << n) - 1);
        my  = y & ((64'd1 << n) - 1);
        sgn = ((x >> n) ^ (y >> n)) & 1;
        if (mx == 0 || my == 0) return 0;
        f   = n - 1 - t;
        opx = (lead(mx) << f) | (frac_of(n, mx) >> t);
        opy = (lead(my) << f) | (frac_of(n, my) >> t);
        c   = (t == 0) ? 0 : ((frac_of(n, mx) >> (t - 1)) & (frac_of(n, my) >> (t - 1)) & 1);
        l   = opx + opy + c;
        e   = l >> f;
        g   = ((l & ((64'd1 << f) - 1)) << t) | ((64'd1 << t) - 1);
        mm  = (64'd1 << (n - 1)) | g;
        mag = (e >= n - 1) ? (mm << (e - (n - 1))) : (mm >> (n - 1 - e));
        return (sgn << (2 * n)) | mag;
    endfunction

    task automatic set_idle();
        bus8.in_valid_i  = 1'b0; bus8.x_i  = '0; bus8.y_i  = '0; bus8.tag_i  = '0; bus8.out_ready_i  = 1'b1;
        bus16.in_valid_i = 1'b0; bus16.x_i = '0; bus16.y_i = '0; bus16.tag_i = '0; bus16.out_ready_i = 1'b1;
        bus0.in_valid_i  = 1'b0; bus0.x_i  = '0; bus0.y_i  = '0; bus0.tag_i  = '0; bus0.out_ready_i  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.in_valid_i = 1'b1; bus8.x_i = 9'h003; bus8.y_i = 9'h005; bus8.tag_i = 4'hA;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus8.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus8.out_valid_o); end
        n_cmp++; if (bus8.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus8.busy_o); end
        n_cmp++; if (bus8.p_o !== 17'h0) begin n_err++; $display("FAIL rst_p: got %h want 0", bus8.p_o); end
        n_cmp++; if (bus8.tag_o !== 4'h0) begin n_err++; $display("FAIL rst_tag: got %h want 0", bus8.tag_o); end
        n_cmp++; if (bus8.in_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus8.in_ready_o); end
        @(negedge clk);
        rst = 1'b0;
        bus8.in_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus8.in_ready_o !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", bus8.in_ready_o); end
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (bus8.busy_o !== 1'b0 || bus8.out_valid_o !== 1'b0) begin
                n_err++; $display("FAIL post_rst_idle: busy %b valid %b want 0 0", bus8.busy_o, bus8.out_valid_o);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_directed();
        logic [8:0]  xs [5];
        logic [8:0]  ys [5];
        logic [3:0]  ts [5];
        logic [16:0] ps [5];
        xs = '{9'h003, 9'h1FF, 9'h001, 9'h100, 9'h000};
        ys = '{9'h005, 9'h0FF, 9'h001, 9'h07F, 9'h1FF};
        ts = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hF};
        ps = '{17'h0000E, 17'h1FF00, 17'h00001, 17'h00000, 17'h00000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus8.out_ready_i = 1'b1;
            bus8.in_valid_i = 1'b1; bus8.x_i = xs[i]; bus8.y_i = ys[i]; bus8.tag_i = ts[i];
            #1;
            n_cmp++; if (bus8.in_ready_o !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, bus8.in_ready_o); end
            @(negedge clk);
            bus8.in_valid_i = 1'b0;
            #1;
            n_cmp++; if (bus8.out_valid_o !== 1'b0 || bus8.busy_o !== 1'b1) begin
                n_err++; $display("FAIL dir_cycle1[%0d]: valid %b busy %b want 0 1", i, bus8.out_valid_o, bus8.busy_o);
            end
            @(negedge clk); #1;
            n_cmp++; if (bus8.out_valid_o !== 1'b0) begin n_err++; $display("FAIL dir_cycle2[%0d]: valid %b want 0", i, bus8.out_valid_o); end
            @(negedge clk); #1;
            n_cmp++; if (bus8.out_valid_o !== 1'b1 || bus8.p_o !== ps[i] || bus8.tag_o !== ts[i]) begin
                n_err++; $display("FAIL dir_result[%0d]: valid %b p %h tag %h want 1 %h %h", i, bus8.out_valid_o, bus8.p_o, bus8.tag_o, ps[i], ts[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] qp [$];
        logic [3:0]  qt [$];
        logic [8:0]  x, y;
        logic [3:0]  tg;
        logic        have = 1'b0;
        logic        stall_prev = 1'b0;
        logic [16:0] held_p = '0;
        logic [3:0]  held_t = '0;
        int          sent = 0;
        int          got = 0;
        int          c = 0;
        while (c < 60 && got < 10) begin
            @(negedge clk);
            bus8.out_ready_i = !(c >= 4 && c <= 7);
            if (!have && sent < 10) begin
                x = 9'($urandom); y = 9'($urandom); tg = 4'($urandom); have = 1'b1;
            end
            bus8.in_valid_i = have; bus8.x_i = x; bus8.y_i = y; bus8.tag_i = tg;
            #1;
            n_cmp++; if (bus8.in_ready_o !== !(c >= 4 && c <= 7)) begin
                n_err++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", c, bus8.in_ready_o, !(c >= 4 && c <= 7));
            end
            if (have && bus8.in_ready_o === 1'b1) begin
                qp.push_back(model(8, 3, 64'(x), 64'(y))); qt.push_back(tg); have = 1'b0; sent++;
            end
            if (bus8.out_valid_o === 1'b1) begin
                if (stall_prev) begin
                    n_cmp++; if (bus8.p_o !== held_p || bus8.tag_o !== held_t) begin
                        n_err++; $display("FAIL bp_hold[c%0d]: p %h tag %h want %h %h", c, bus8.p_o, bus8.tag_o, held_p, held_t);
                    end
                end
                if (bus8.out_ready_i) begin
                    n_cmp++;
                    if (qp.size() == 0) begin
                        n_err++; $display("FAIL bp_extra[c%0d]: p %h with nothing expected", c, bus8.p_o);
                    end else begin
                        if (64'(bus8.p_o) !== qp[0] || bus8.tag_o !== qt[0]) begin
                            n_err++; $display("FAIL bp_result[%0d]: p %h tag %h want %h %h", got, bus8.p_o, bus8.tag_o, qp[0], qt[0]);
                        end
                        void'(qp.pop_front()); void'(qt.pop_front());
                    end
                    got++;
                end
            end
            stall_prev = (bus8.out_valid_o === 1'b1) && !bus8.out_ready_i;
            held_p = bus8.p_o; held_t = bus8.tag_o;
            c++;
        end
        bus8.in_valid_i = 1'b0;
        bus8.out_ready_i = 1'b1;
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL bp_count: got %0d results want 10", got); end
    endtask

    task automatic test_reset_mid();
        logic [8:0]  x, y;
        logic [3:0]  tg;
        logic [16:0] exp_p;
        @(negedge clk);
        bus8.out_ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            bus8.in_valid_i = 1'b1;
            bus8.x_i = 9'($urandom) | 9'h001; bus8.y_i = 9'($urandom) | 9'h001; bus8.tag_i = 4'($urandom);
            #1;
            n_cmp++; if (bus8.in_ready_o !== 1'b1) begin n_err++; $display("FAIL rm_in_ready[%0d]: got %b want 1", j, bus8.in_ready_o); end
        end
        @(negedge clk);
        bus8.in_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus8.out_valid_o !== 1'b0 || bus8.busy_o !== 1'b0 || bus8.p_o !== 17'h0) begin
            n_err++; $display("FAIL rm_after_rst: valid %b busy %b p %h want 0 0 0", bus8.out_valid_o, bus8.busy_o, bus8.p_o);
        end
        bus8.out_ready_i = 1'b1;
        @(negedge clk);
        x = 9'($urandom); y = 9'($urandom); tg = 4'($urandom);
        bus8.in_valid_i = 1'b1; bus8.x_i = x; bus8.y_i = y; bus8.tag_i = tg;
        exp_p = 17'(model(8, 3, 64'(x), 64'(y)));
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            bus8.in_valid_i = 1'b0;
            #1;
            n_cmp++; if (bus8.out_valid_o !== (j == 3)) begin
                n_err++; $display("FAIL rm_valid[%0d]: got %b want %b", j, bus8.out_valid_o, (j == 3));
            end
            if (j == 3) begin
                n_cmp++; if (bus8.p_o !== exp_p || bus8.tag_o !== tg) begin
                    n_err++; $display("FAIL rm_new_beat: p %h tag %h want %h %h", bus8.p_o, bus8.tag_o, exp_p, tg);
                end
            end
        end
    endtask

    // which: 0 = N8/T3, 1 = N16/T5, 2 = N8/T0
    task automatic test_random(input int which, input int cycles);
        logic [63:0] qp [$];
        logic [3:0]  qt [$];
        logic [63:0] x = '0, y = '0, p, held_p = '0, mask;
        logic [3:0]  tg = '0, to, held_t = '0;
        logic        have = 1'b0, ord, ov, ir, stall_prev = 1'b0;
        int          n, t;
        n = (which == 1) ? 16 : 8;
        t = (which == 0) ? 3 : (which == 1) ? 5 : 0;
        mask = (64'd1 << n) - 1;
        for (int c = 0; c < cycles + 30; c++) begin
            @(negedge clk);
            ord = (c >= cycles) ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (!have && c < cycles && $urandom_range(0, 9) < 8) begin
                x = 64'($urandom) & mask; y = 64'($urandom) & mask;
                if ($urandom_range(0, 15) == 0) x = 0;
                if ($urandom_range(0, 15) == 0) y = mask;
                x = x | (64'($urandom_range(0, 1)) << n);
                y = y | (64'($urandom_range(0, 1)) << n);
                tg = 4'($urandom); have = 1'b1;
            end
            case (which)
                0: begin bus8.in_valid_i = have; bus8.x_i = x[8:0]; bus8.y_i = y[8:0]; bus8.tag_i = tg; bus8.out_ready_i = ord; end
                1: begin bus16.in_valid_i = have; bus16.x_i = x[16:0]; bus16.y_i = y[16:0]; bus16.tag_i = tg; bus16.out_ready_i = ord; end
                default: begin bus0.in_valid_i = have; bus0.x_i = x[8:0]; bus0.y_i = y[8:0]; bus0.tag_i = tg; bus0.out_ready_i = ord; end
            endcase
            #1;
            case (which)
                0: begin ov = bus8.out_valid_o; ir = bus8.in_ready_o; p = 64'(bus8.p_o); to = bus8.tag_o; end
                1: begin ov = bus16.out_valid_o; ir = bus16.in_ready_o; p = 64'(bus16.p_o); to = bus16.tag_o; end
                default: begin ov = bus0.out_valid_o; ir = bus0.in_ready_o; p = 64'(bus0.p_o); to = bus0.tag_o; end
            endcase
            if (have && ir === 1'b1) begin
                qp.push_back(model(n, t, x, y)); qt.push_back(tg); have = 1'b0;
            end
            if (ov === 1'b1) begin
                if (stall_prev) begin
                    n_cmp++; if (p !== held_p || to !== held_t) begin
                        n_err++; $display("FAIL rnd%0d_hold[c%0d]: p %h tag %h want %h %h", which, c, p, to, held_p, held_t);
                    end
                end
                if (ord) begin
                    n_cmp++;
                    if (qp.size() == 0) begin
                        n_err++; $display("FAIL rnd%0d_extra[c%0d]: p %h with nothing expected", which, c, p);
                    end else begin
                        if (p !== qp[0] || to !== qt[0]) begin
                            n_err++; $display("FAIL rnd%0d_result[c%0d]: p %h tag %h want %h %h", which, c, p, to, qp[0], qt[0]);
                        end
                        void'(qp.pop_front()); void'(qt.pop_front());
                    end
                end
            end
            stall_prev = (ov === 1'b1) && !ord;
            held_p = p; held_t = to;
        end
        set_idle();
        n_cmp++; if (qp.size() != 0 || have) begin
            n_err++; $display("FAIL rnd%0d_drain: %0d results missing, pending %b want 0 0", which, qp.size(), have);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        set_idle();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(0, 3000);
        test_random(1, 4000);
        test_random(2, 3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
